// File: rtl/alu_pkg.sv
// Constants and types shared between the ALU ENC operation and the stream decoder.
// The key default must stay identical on both sides of the link.
package alu_pkg;

  localparam logic [7:0] ENC_KEY_DEFAULT   = 8'hAB;
  localparam int         DEC_DEPTH_DEFAULT = 4;
  localparam int         NIBBLE_W          = 4;
  localparam int         BYTE_W            = 2 * NIBBLE_W;

  typedef struct packed {
    logic [NIBBLE_W-1:0] a;
    logic [NIBBLE_W-1:0] b;
  } nibble_pair_t;

  function automatic logic [BYTE_W-1:0] rotl1(input logic [BYTE_W-1:0] v);
    return {v[BYTE_W-2:0], v[BYTE_W-1]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head entry is read straight from storage.
// Reads return zero while empty so downstream data lines stay quiet.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Same index with opposite wrap bits means the writer has lapped the reader.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/enc_stream_decoder.sv
// Receive side of the ALU ENC path: XOR-decodes ciphertext bytes with the current key
// and queues the recovered nibble pairs for the operand checker.
module enc_stream_decoder
  import alu_pkg::*;
#(
  parameter logic [7:0] KEY   = ENC_KEY_DEFAULT,
  parameter int         DEPTH = DEC_DEPTH_DEFAULT,
  parameter bit         ROLL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       key_load,
  input  logic [7:0] key_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_a,
  output logic [3:0] out_b,
  output logic [7:0] count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and ready is never a function of the same port's valid.

  logic [7:0]   key_q, key_d;
  logic [7:0]   count_q, count_d;
  logic         live_q;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic [7:0]   head_data;
  nibble_pair_t head;

  // live_q holds in_ready low until the first edge after reset is released.
  assign in_ready  = !fifo_full && !key_load && live_q && !rst;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head  = head_data;
  assign out_a = head.a;
  assign out_b = head.b;
  assign count = count_q;

  always_comb begin
    key_d   = key_q;
    count_d = count_q;
    if (key_load)          key_d = key_in;
    else if (ROLL && push) key_d = rotl1(key_q);
    if (pop)               count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= KEY;
      count_q <= '0;
      live_q  <= 1'b0;
    end else begin
      key_q   <= key_d;
      count_q <= count_d;
      live_q  <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(in_data ^ key_q),
    .rdata_o(head_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_enc_stream_decoder.sv
// Bench for enc_stream_decoder: a fixed-key and a rolling-key instance share one stimulus
// stream and are checked every cycle against a queue-based model of the decoder.
module tb_enc_stream_decoder;

  localparam logic [7:0] KEY   = 8'hAB;
  localparam int         DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       key_load;
  logic [7:0] key_in;
  logic       out_ready;
  logic       in_ready_w  [2];
  logic       out_valid_w [2];
  logic [3:0] out_a_w     [2];
  logic [3:0] out_b_w     [2];
  logic [7:0] count_w     [2];

  int         n_cmp;
  int         n_fail;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] mkey [2];
  logic [7:0] mcnt;
  bit         live;

  enc_stream_decoder #(.KEY(KEY), .DEPTH(DEPTH), .ROLL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
    .key_load(key_load), .key_in(key_in), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_a(out_a_w[0]), .out_b(out_b_w[0]), .count(count_w[0])
  );

  enc_stream_decoder #(.KEY(KEY), .DEPTH(DEPTH), .ROLL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
    .key_load(key_load), .key_in(key_in), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_a(out_a_w[1]), .out_b(out_b_w[1]), .count(count_w[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input int i, input int sz, input logic [7:0] head);
    chk($sformatf("in_ready%0d", i), 8'(in_ready_w[i]), 8'(live && (sz < DEPTH) && !key_load));
    chk($sformatf("out_valid%0d", i), 8'(out_valid_w[i]), 8'(sz != 0));
    chk($sformatf("out_a%0d", i), 8'(out_a_w[i]), 8'(head[7:4]));
    chk($sformatf("out_b%0d", i), 8'(out_b_w[i]), 8'(head[3:0]));
    chk($sformatf("count%0d", i), count_w[i], mcnt);
  endtask

  task automatic check_outputs();
    logic [7:0] h0, h1;
    h0 = 8'h00;
    h1 = 8'h00;
    if (exp_q0.size() != 0) h0 = exp_q0[0];
    if (exp_q1.size() != 0) h1 = exp_q1[0];
    chk_inst(0, exp_q0.size(), h0);
    chk_inst(1, exp_q1.size(), h1);
  endtask

  // driver: one clock cycle of stimulus, checked before the edge, model advanced across it
  task automatic step(input bit v, input logic [7:0] d, input bit kl, input logic [7:0] ki,
                      input bit ordy);
    bit do_push, do_pop;
    in_valid  = v;
    in_data   = d;
    key_load  = kl;
    key_in    = ki;
    out_ready = ordy;
    #1;
    check_outputs();
    do_push = v && live && (exp_q0.size() < DEPTH) && !kl;
    do_pop  = (exp_q0.size() != 0) && ordy;
    if (do_pop) begin
      void'(exp_q0.pop_front());
      void'(exp_q1.pop_front());
      mcnt = mcnt + 8'd1;
    end
    if (do_push) begin
      exp_q0.push_back(d ^ mkey[0]);
      exp_q1.push_back(d ^ mkey[1]);
    end
    if (kl) begin
      mkey[0] = ki;
      mkey[1] = ki;
    end else if (do_push) begin
      mkey[1] = {mkey[1][6:0], mkey[1][7]};
    end
    @(posedge clk);
    #1;
    live = 1'b1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 8'h00, 1'b0, 8'h00, ordy);
  endtask

  task automatic push_byte(input logic [7:0] d, input bit ordy);
    step(1'b1, d, 1'b0, 8'h00, ordy);
  endtask

  // Reset is raised between edges so its effect is seen before any clock arrives.
  task automatic apply_reset();
    in_valid  = 1'b0;
    key_load  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_in_ready%0d", i), 8'(in_ready_w[i]), 8'h00);
      chk($sformatf("rst_out_valid%0d", i), 8'(out_valid_w[i]), 8'h00);
      chk($sformatf("rst_out_a%0d", i), 8'(out_a_w[i]), 8'h00);
      chk($sformatf("rst_out_b%0d", i), 8'(out_b_w[i]), 8'h00);
      chk($sformatf("rst_count%0d", i), count_w[i], 8'h00);
    end
    exp_q0.delete();
    exp_q1.delete();
    mkey[0] = KEY;
    mkey[1] = KEY;
    mcnt    = 8'h00;
    live    = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rel_in_ready0", 8'(in_ready_w[0]), 8'h00);
    @(posedge clk);
    #1;
    live = 1'b1;
  endtask

  // directed steps followed by a random phase
  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    key_load  = 1'b0;
    key_in    = 8'h00;
    out_ready = 1'b0;
    live      = 1'b0;
    mcnt      = 8'h00;
    mkey[0]   = KEY;
    mkey[1]   = KEY;
    @(posedge clk);
    #1;
    apply_reset();

    // basic decode
    push_byte(8'hF8, 1'b1);
    chk("t1_valid", 8'(out_valid_w[0]), 8'h01);
    chk("t1_a", 8'(out_a_w[0]), 8'h05);
    chk("t1_b", 8'(out_b_w[0]), 8'h03);
    idle(1'b1);
    chk("t1_count", count_w[0], 8'h01);

    // fill, blocked push while full, pop releases space
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)), 1'b0);
    chk("t2_full_ready", 8'(in_ready_w[0]), 8'h00);
    begin
      logic [7:0] d5;
      d5 = 8'($urandom_range(0, 255));
      push_byte(d5, 1'b0);
      chk("t2_held_ready", 8'(in_ready_w[0]), 8'h00);
      push_byte(d5, 1'b1);
      chk("t2_after_pop_ready", 8'(in_ready_w[0]), 8'h01);
      push_byte(d5, 1'b0);
    end
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("t2_drained", 8'(out_valid_w[0]), 8'h00);

    // rolling key on dut1
    apply_reset();
    push_byte(8'hF8, 1'b0);
    push_byte(8'hF8, 1'b0);
    chk("t3_a0", 8'(out_a_w[1]), 8'h05);
    chk("t3_b0", 8'(out_b_w[1]), 8'h03);
    idle(1'b1);
    chk("t3_a1", 8'(out_a_w[1]), 8'h0A);
    chk("t3_b1", 8'(out_b_w[1]), 8'h0F);
    push_byte(8'h00, 1'b1);
    idle(1'b0);
    chk("t3_key_a", 8'(out_a_w[1]), 8'h0A);
    chk("t3_key_b", 8'(out_b_w[1]), 8'h0E);

    // key load blocks push, new key applies to the next byte
    apply_reset();
    step(1'b1, 8'h77, 1'b1, 8'h00, 1'b0);
    chk("t4_no_push", 8'(out_valid_w[0]), 8'h00);
    push_byte(8'h53, 1'b0);
    chk("t4_a0", 8'(out_a_w[0]), 8'h05);
    chk("t4_b0", 8'(out_b_w[0]), 8'h03);
    chk("t4_a1", 8'(out_a_w[1]), 8'h05);
    chk("t4_b1", 8'(out_b_w[1]), 8'h03);
    idle(1'b1);

    // reset mid-stream with three entries queued and count=2
    apply_reset();
    push_byte(8'($urandom_range(0, 255)), 1'b0);
    push_byte(8'($urandom_range(0, 255)), 1'b1);
    push_byte(8'($urandom_range(0, 255)), 1'b1);
    push_byte(8'($urandom_range(0, 255)), 1'b0);
    push_byte(8'($urandom_range(0, 255)), 1'b0);
    chk("t5_count", count_w[0], 8'h02);
    apply_reset();
    push_byte(8'hF8, 1'b0);
    chk("t5_a", 8'(out_a_w[0]), 8'h05);
    chk("t5_b", 8'(out_b_w[0]), 8'h03);

    // count wrap over 256 back-to-back pops
    apply_reset();
    push_byte(8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 255; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(1'b1);
    chk("t6_wrap0", count_w[0], 8'h00);
    chk("t6_wrap1", count_w[1], 8'h00);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    chk("final_empty", 8'(out_valid_w[0]), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
